// File: rtl/uart_periph_pkg.sv
// Shared types for the UART peripheral: register map, control word layout,
// supported line rates and the frame-level state encoding used by both FSMs.
package uart_periph_pkg;

  localparam int unsigned ARCH_WIDTH     = 32;
  localparam int unsigned UART_DATA_BITS = 8;

  // Line rates; the enum value is the rate in baud.
  typedef enum logic [31:0] {
    BR_9600   = 32'd9600,
    BR_19200  = 32'd19200,
    BR_38400  = 32'd38400,
    BR_57600  = 32'd57600,
    BR_115200 = 32'd115200
  } uart_baud_rate_t;

  // Register map; address 2'd3 is an unnamed read-as-zero slot.
  typedef enum logic [1:0] {
    UART_CTRL = 2'd0,
    UART_RX   = 2'd1,
    UART_TX   = 2'd2
  } uart_addr_t;

  typedef struct packed {
    logic rx_valid;
    logic tx_ready;
  } uart_ctrl_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_periph_if.sv
// Valid/ready channels used by the peripheral.
//   rv_if_da : request channel carrying addr + wdata (TX = initiator, RX = target)
//   rv_if    : response channel carrying data     (TX = initiator, RX = target)
interface rv_if_da #(
  parameter int unsigned AW = 2,
  parameter int unsigned DW = uart_periph_pkg::ARCH_WIDTH
);
  logic          valid;
  logic          ready;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;

  modport TX (output valid, output addr, output wdata, input  ready);
  modport RX (input  valid, input  addr, input  wdata, output ready);
endinterface

interface rv_if #(
  parameter int unsigned DW = uart_periph_pkg::ARCH_WIDTH
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport TX (output valid, output data, input  ready);
  modport RX (input  valid, input  data, output ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period down-counter.
//   clk, rst : clock, synchronous active-high reset
//   load_i   : restart the count (full period, or half period when half_i=1)
//   half_i   : select CLKS_PER_BIT/2-1 as load value
//   tick_o   : high for the one cycle in which the count is zero
// After reaching zero the counter reloads a full period on its own, so a
// single half-period load lines up all later ticks on bit mid-points.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic half_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  // Next count: explicit load, auto-reload at zero, otherwise decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = half_i ? HALF_LOAD : FULL_LOAD;
    end else if (cnt_q == '0) begin
      cnt_d = FULL_LOAD;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // tick_q mirrors (cnt_q == 0) but comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= FULL_LOAD;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == '0);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART with a one-byte RX buffer.
//   clk, rst : core clock, synchronous active-high reset
//   req      : request channel (addr = uart_addr_t, wdata[7:0] = TX byte)
//   rsp      : read response channel, data held until accepted
//   uart_rx  : asynchronous serial input
//   uart_tx  : serial output, idle high
module uart_periph
  import uart_periph_pkg::*;
#(
  parameter int unsigned     CLOCK_FREQ = 100_000_000,
  parameter uart_baud_rate_t BAUD_RATE  = BR_115200
) (
  input  logic clk,
  input  logic rst,
  rv_if_da.RX  req,
  rv_if.TX     rsp,
  input  logic uart_rx,
  output logic uart_tx
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / 32'(BAUD_RATE);
  localparam logic [2:0]  LAST_BIT     = 3'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_periph: CLKS_PER_BIT must be at least 4");
  end

  // ---------------------------------------------------------------- bus side
  uart_addr_t      req_addr;
  logic            req_fire, rd_fire, tx_start, rx_clear, tx_ready;
  logic [ARCH_WIDTH-1:0] rd_data;
  logic            rsp_valid_q;
  logic [ARCH_WIDTH-1:0] rsp_data_q;
  logic            unused_wdata;

  uart_state_t     tx_state_q;
  logic [2:0]      tx_idx_q;
  logic [7:0]      tx_shift_q;
  logic            uart_tx_q;
  logic            tx_tick;

  logic [1:0]      rx_sync_q;
  logic            rx_prev_q, rx_s, rx_fall, rx_tick, rx_set;
  uart_state_t     rx_state_q;
  logic [2:0]      rx_idx_q;
  logic [7:0]      rx_shift_q;
  logic [7:0]      rx_data_q;
  logic            rx_valid_q;

  // A pending, unaccepted response blocks new requests.
  assign req.ready = !(rsp_valid_q && !rsp.ready);
  assign req_fire  = req.valid && req.ready;
  assign req_addr  = uart_addr_t'(req.addr);
  assign tx_ready  = (tx_state_q == IDLE);
  assign tx_start  = req_fire && (req_addr == UART_TX) && tx_ready;
  assign rd_fire   = req_fire && (req_addr != UART_TX);
  assign rx_clear  = req_fire && (req_addr == UART_RX);
  assign unused_wdata = ^req.wdata[ARCH_WIDTH-1:8];

  // Read data mux.
  always_comb begin
    rd_data = '0;
    case (req_addr)
      UART_CTRL: rd_data = ARCH_WIDTH'(uart_ctrl_t'{rx_valid: rx_valid_q, tx_ready: tx_ready});
      UART_RX:   rd_data = ARCH_WIDTH'(rx_data_q);
      default:   rd_data = '0;
    endcase
  end

  // Response register: loads on a read, drops when consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else if (rd_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= rd_data;
    end else if (rsp.ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp.valid = rsp_valid_q;
  assign rsp.data  = rsp_data_q;

  // ---------------------------------------------------------------- TX path
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tx_start),
    .half_i (1'b0),
    .tick_o (tx_tick)
  );

  // TX FSM: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= IDLE;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      uart_tx_q  <= 1'b1;
    end else begin
      case (tx_state_q)
        IDLE: if (tx_start) begin
          tx_state_q <= START;
          tx_shift_q <= req.wdata[7:0];
          uart_tx_q  <= 1'b0;
        end
        START: if (tx_tick) begin
          tx_state_q <= DATA;
          tx_idx_q   <= '0;
          uart_tx_q  <= tx_shift_q[0];
        end
        DATA: if (tx_tick) begin
          if (tx_idx_q == LAST_BIT) begin
            tx_state_q <= STOP;
            uart_tx_q  <= 1'b1;
          end else begin
            tx_idx_q   <= tx_idx_q + 3'd1;
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            uart_tx_q  <= tx_shift_q[1];
          end
        end
        STOP: if (tx_tick) begin
          tx_state_q <= IDLE;
        end
      endcase
    end
  end

  assign uart_tx = uart_tx_q;

  // ---------------------------------------------------------------- RX path
  // Two-flop synchroniser plus edge history, all idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      rx_sync_q <= {rx_sync_q[0], uart_rx};
      rx_prev_q <= rx_sync_q[1];
    end
  end

  assign rx_s    = rx_sync_q[1];
  assign rx_fall = rx_prev_q && !rx_s;

  // Half-period load on the start edge puts every later tick at mid-bit.
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i ((rx_state_q == IDLE) && rx_fall),
    .half_i (1'b1),
    .tick_o (rx_tick)
  );

  // RX FSM: returns to IDLE right after the stop-bit sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= IDLE;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      case (rx_state_q)
        IDLE: if (rx_fall) begin
          rx_state_q <= START;
        end
        START: if (rx_tick) begin
          rx_state_q <= rx_s ? IDLE : DATA;
          rx_idx_q   <= '0;
        end
        DATA: if (rx_tick) begin
          rx_shift_q <= {rx_s, rx_shift_q[7:1]};
          if (rx_idx_q == LAST_BIT) begin
            rx_state_q <= STOP;
          end else begin
            rx_idx_q <= rx_idx_q + 3'd1;
          end
        end
        STOP: if (rx_tick) begin
          rx_state_q <= IDLE;
        end
      endcase
    end
  end

  // Good stop bit commits the byte; a bad one leaves the buffer untouched.
  assign rx_set = (rx_state_q == STOP) && rx_tick && rx_s;

  // RX buffer: a new byte wins over a same-cycle read clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else if (rx_set) begin
      rx_data_q  <= rx_shift_q;
      rx_valid_q <= 1'b1;
    end else if (rx_clear) begin
      rx_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
// Directed self-checking bench for uart_periph at CPB = 10.
module tb_uart_periph;
  import uart_periph_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic uart_rx;
  logic uart_tx;
  int   checks = 0;
  int   errors = 0;

  rv_if_da #(.AW(2), .DW(32)) req_if ();
  rv_if    #(.DW(32))         rsp_if ();

  uart_periph #(
    .CLOCK_FREQ (1_152_000),
    .BAUD_RATE  (BR_115200)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req_if),
    .rsp     (rsp_if),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One-cycle read with rsp.ready high; returns the response seen at T+1.
  task automatic bus_read(input logic [1:0] a, output logic v, output logic [31:0] d);
    @(negedge clk);
    req_if.valid = 1'b1;
    req_if.addr  = a;
    @(negedge clk);
    req_if.valid = 1'b0;
    v = rsp_if.valid;
    d = rsp_if.data;
  endtask

  // Drive one 8N1 frame (10 cycles per bit); optionally read UART_RX at cycle rd_at.
  task automatic send_rx(input logic [7:0] b, input logic stop, input int rd_at,
                         output logic v, output logic [31:0] d);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    v = 1'b0;
    d = '0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      uart_rx = fr[j / 10];
      if (j == rd_at + 1) begin
        req_if.valid = 1'b0;
        v = rsp_if.valid;
        d = rsp_if.data;
      end
      if (j == rd_at) begin
        req_if.valid = 1'b1;
        req_if.addr  = 2'd1;
      end
    end
    @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic test_reset();
    logic v;
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx got %b exp 1", uart_tx); end
    checks++; if (req_if.ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_if.ready); end
    checks++; if (rsp_if.valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_if.valid); end
    checks++; if (rsp_if.data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_if.data); end
    rst = 1'b0;
    bus_read(2'd0, v, d);
    checks++; if (v !== 1'b1 || d !== 32'h1) begin errors++; $display("FAIL reset_ctrl got v=%b d=%h exp v=1 d=00000001", v, d); end
  endtask

  task automatic test_tx_frame();
    logic [7:0] b;
    logic       e;
    b = 8'hA5;
    @(negedge clk);
    req_if.valid = 1'b1; req_if.addr = 2'd2; req_if.wdata = 32'hA5;
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      if (k <= 10)      e = 1'b0;
      else if (k <= 90) e = b[(k - 11) / 10];
      else              e = 1'b1;
      checks++; if (uart_tx !== e) begin errors++; $display("FAIL tx_line T+%0d got %b exp %b", k, uart_tx, e); end
      if (k == 51) begin
        checks++; if (rsp_if.valid !== 1'b1 || rsp_if.data !== 32'h0) begin
          errors++; $display("FAIL tx_busy_ctrl got v=%b d=%h exp v=1 d=00000000", rsp_if.valid, rsp_if.data); end
      end
      if (k == 102) begin
        checks++; if (rsp_if.valid !== 1'b1 || rsp_if.data !== 32'h1) begin
          errors++; $display("FAIL tx_done_ctrl got v=%b d=%h exp v=1 d=00000001", rsp_if.valid, rsp_if.data); end
      end
      req_if.valid = 1'b0;
      if (k == 20) begin req_if.valid = 1'b1; req_if.addr = 2'd2; req_if.wdata = 32'h3C; end
      if (k == 50 || k == 101) begin req_if.valid = 1'b1; req_if.addr = 2'd0; end
    end
    req_if.valid = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic v;
    logic [31:0] d;
    @(negedge clk);
    req_if.valid = 1'b1; req_if.addr = 2'd2; req_if.wdata = 32'h00;
    @(negedge clk);
    req_if.valid = 1'b0;
    repeat (24) @(negedge clk);
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL midframe_line got %b exp 0", uart_tx); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL midframe_reset_tx got %b exp 1", uart_tx); end
    bus_read(2'd0, v, d);
    checks++; if (v !== 1'b1 || d !== 32'h1) begin errors++; $display("FAIL midframe_ctrl got v=%b d=%h exp v=1 d=00000001", v, d); end
    repeat (20) @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL midframe_idle got %b exp 1", uart_tx); end
  endtask

  task automatic test_rx_byte();
    logic v;
    logic [31:0] d;
    send_rx(8'h5A, 1'b1, 1000, v, d);
    repeat (5) @(negedge clk);
    bus_read(2'd0, v, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL rx_ctrl_full got %h exp 00000003", d); end
    bus_read(2'd1, v, d);
    checks++; if (v !== 1'b1 || d !== 32'h5A) begin errors++; $display("FAIL rx_data got v=%b d=%h exp v=1 d=0000005a", v, d); end
    bus_read(2'd0, v, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rx_ctrl_cleared got %h exp 00000001", d); end
  endtask

  task automatic test_rx_errors();
    logic v;
    logic [31:0] d;
    @(negedge clk); uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    bus_read(2'd0, v, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rx_glitch got %h exp 00000001", d); end
    send_rx(8'h77, 1'b0, 1000, v, d);
    repeat (5) @(negedge clk);
    bus_read(2'd0, v, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rx_framing got %h exp 00000001", d); end
    bus_read(2'd1, v, d);
    checks++; if (d !== 32'h5A) begin errors++; $display("FAIL rx_framing_data got %h exp 0000005a", d); end
  endtask

  task automatic test_overrun();
    logic v;
    logic [31:0] d;
    send_rx(8'h11, 1'b1, 1000, v, d);
    send_rx(8'h22, 1'b1, 1000, v, d);
    repeat (5) @(negedge clk);
    bus_read(2'd0, v, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL overrun_ctrl got %h exp 00000003", d); end
    bus_read(2'd1, v, d);
    checks++; if (d !== 32'h22) begin errors++; $display("FAIL overrun_data got %h exp 00000022", d); end
  endtask

  task automatic test_read_collision();
    logic v;
    logic [31:0] d;
    send_rx(8'h33, 1'b1, 1000, v, d);
    send_rx(8'h44, 1'b1, 97, v, d);
    checks++; if (v !== 1'b1 || d !== 32'h33) begin errors++; $display("FAIL collide_old got v=%b d=%h exp v=1 d=00000033", v, d); end
    repeat (5) @(negedge clk);
    bus_read(2'd0, v, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL collide_ctrl got %h exp 00000003", d); end
    bus_read(2'd1, v, d);
    checks++; if (d !== 32'h44) begin errors++; $display("FAIL collide_new got %h exp 00000044", d); end
    bus_read(2'd0, v, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL collide_cleared got %h exp 00000001", d); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] a [3];
    logic [31:0] e [3];
    a[0] = 2'd0; a[1] = 2'd3; a[2] = 2'd0;
    e[0] = 32'h1; e[1] = 32'h0; e[2] = 32'h1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (rsp_if.valid !== 1'b1 || rsp_if.data !== e[i-1]) begin
          errors++; $display("FAIL b2b_rsp%0d got v=%b d=%h exp v=1 d=%h", i - 1, rsp_if.valid, rsp_if.data, e[i-1]); end
      end
      req_if.valid = (i < 3);
      if (i < 3) req_if.addr = a[i];
    end
    @(negedge clk);
    checks++; if (rsp_if.valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", rsp_if.valid); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    rsp_if.ready = 1'b0;
    req_if.valid = 1'b1; req_if.addr = 2'd0;
    @(negedge clk);
    req_if.addr = 2'd3;
    for (int k = 1; k <= 5; k++) begin
      checks++; if (rsp_if.valid !== 1'b1 || rsp_if.data !== 32'h1 || req_if.ready !== 1'b0) begin
        errors++; $display("FAIL bp_stall T+%0d got v=%b d=%h rdy=%b exp v=1 d=00000001 rdy=0",
                           k, rsp_if.valid, rsp_if.data, req_if.ready); end
      if (k < 5) @(negedge clk);
    end
    @(negedge clk);
    rsp_if.ready = 1'b1;
    @(negedge clk);
    req_if.valid = 1'b0;
    checks++; if (rsp_if.valid !== 1'b1 || rsp_if.data !== 32'h0) begin
      errors++; $display("FAIL bp_next got v=%b d=%h exp v=1 d=00000000", rsp_if.valid, rsp_if.data); end
    @(negedge clk);
    checks++; if (rsp_if.valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", rsp_if.valid); end
  endtask

  initial begin
    rst          = 1'b1;
    uart_rx      = 1'b1;
    req_if.valid = 1'b0;
    req_if.addr  = 2'd0;
    req_if.wdata = 32'h0;
    rsp_if.ready = 1'b1;
    test_reset();
    test_tx_frame();
    test_reset_midframe();
    test_rx_byte();
    test_rx_errors();
    test_overrun();
    test_read_collision();
    test_back_to_back();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_periph.md
# uart_periph

Memory-mapped UART peripheral. It sits directly downstream of the core's data-memory path for the UART address window. It accepts single-word requests on a valid/ready request channel and returns read data on a valid/ready response channel. It serialises TX bytes as 8N1 and deserialises RX bytes as 8N1, with one byte of RX buffering.

## Interface
- `CLOCK_FREQ`, default 100_000_000: core clock in Hz.
- `BAUD_RATE`, default `BR_115200`: `uart_baud_rate_t` line rate.
- `CLKS_PER_BIT`, derived, `CLOCK_FREQ/BAUD_RATE` (truncating): elaboration error if < 4.
- `clk`  in  1  core clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  `rv_if_da.RX` (AW=2, DW=`ARCH_WIDTH`)  in  request.
  - `addr` is a `uart_addr_t`.
  - `wdata[7:0]` is the TX byte.
- `rsp`  `rv_if.TX` (DW=`ARCH_WIDTH`)  out  read response.
- `uart_rx`  in  1  serial input, asynchronous to `clk`.
- `uart_tx`  out  1  serial output; idle high.

## Operation
- **Request acceptance.** A request is accepted when `req.valid && req.ready`.
  - `req.ready = !(rsp.valid && !rsp.ready)`, so a stalled response blocks new requests.
- **Address decode:**
  - `UART_CTRL`: read. Returns `{30'b0, uart_ctrl_t'{rx_valid, tx_ready}}`, i.e. bit1 = rx_valid, bit0 = tx_ready.
  - `UART_RX`: read. Returns `{24'b0, rx_data}` and clears rx_valid on the accept cycle.
  - `UART_TX`: write. Starts a frame with `wdata[7:0]` if tx_ready=1; silently dropped if tx_ready=0. No response is generated.
  - Addr 2'd3: read, returns 0, no side effect.
- **TX FSM:**
  - States: IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE.
  - Each state lasts `CLKS_PER_BIT` cycles, counted by a bit-timer plus a 3-bit bit index.
  - tx_ready = (state == IDLE).
- **RX path:**
  - `uart_rx` passes through a 2-flop synchroniser; the synchroniser resets to 1.
  - RX FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE → START on the synchronised falling edge.
  - START samples at `CLKS_PER_BIT/2`. If the line is high there, it is a false start and the FSM returns to IDLE.
  - DATA samples 8 bits every `CLKS_PER_BIT` from the mid-point, shifting LSB first.
  - STOP samples at mid-bit:
    - High: load rx_data and set rx_valid.
    - Low: framing error; the byte is discarded and rx_valid/rx_data are unchanged.
  - The FSM returns to IDLE right after the STOP sample; it does not wait for the full stop bit.
- **Boundary cases:**
  - Overrun: a new valid byte overwrites rx_data; rx_valid stays 1.
  - A `UART_RX` read in the same cycle as a new byte load: the read returns the old byte, the new byte is stored, and rx_valid stays 1 (set wins over clear).
  - A `UART_TX` write in the cycle the STOP state ends is dropped, because tx_ready is still 0.
  - Reset mid-frame: both FSMs go to IDLE and uart_tx=1 on the next cycle. A partial RX byte is discarded.

## Timing
- **Reset values:** uart_tx=1, tx_ready=1, rx_valid=0, rx_data=0, rsp.valid=0, rsp.data=0, req.ready=1.
- **Read latency:** `rsp.valid` rises in cycle T+1 after a read accepted at T. The response holds data stable until `rsp.ready`. Back-to-back reads sustain 1/cycle when rsp.ready=1.
- **TX timing** for a write accepted at T:
  - uart_tx=0 for cycles T+1..T+CPB.
  - Data bit i occupies T+1+(i+1)·CPB for CPB cycles.
  - Stop bit (1) occupies T+1+9·CPB..T+10·CPB.
  - tx_ready=0 for T+1..T+10·CPB and returns to 1 at T+10·CPB+1.
- **RX timing:**
  - The synchroniser adds 2 cycles.
  - rx_valid rises 1 cycle after the stop-bit mid sample, i.e. about 2 + 9.5·CPB + 1 cycles after the line's falling edge.

## Structure
- The shared types package holds `uart_ctrl_t`, `uart_addr_t` and `uart_baud_rate_t`.
- Add `UART_DATA_BITS = 8` to the shared package, plus a `uart_state_t` enum (IDLE, START, DATA, STOP) used by both FSMs.
- One sub-module, `uart_bit_timer`, is instantiated twice, once for TX and once for RX.
  - It is a down-counter with load value `CLKS_PER_BIT-1` or `CLKS_PER_BIT/2-1`.
  - It raises a `tick` pulse when it reaches 0.

## Test plan
Bench settings: `CLOCK_FREQ=1_152_000`, `BR_115200`, giving CPB=10.
- **Reset:** hold rst 3 cycles -> uart_tx=1; a read of `UART_CTRL` returns 0x1 one cycle after accept.
- **TX frame:** write 0xA5 to `UART_TX` at T -> line reads 0 / 1,0,1,0,0,1,0,1 / 1 in 10-cycle slots starting at T+1. Reading `UART_CTRL` at T+50 gives 0x0; at T+101 it gives 0x1.
- **TX busy drop:** second write 0x3C at T+20 -> only 0xA5 is transmitted; the line stays idle after T+100.
- **RX byte:** drive 0x5A frame on uart_rx -> `UART_CTRL` read returns 0x3, then a `UART_RX` read returns 0x5A, then `UART_CTRL` returns 0x1.
- **RX errors:**
  - 3-cycle low glitch -> no rx_valid.
  - Frame 0x77 with stop=0 -> rx_valid stays 0.
  - Two frames 0x11 then 0x22 without a read -> `UART_RX` returns 0x22.
- **Backpressure:** hold rsp.ready=0 for 5 cycles after a read -> rsp.valid and rsp.data are stable and req.ready=0 throughout; the next request is accepted the cycle after rsp.ready=1.
